// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and word-select helper for the direct-mapped,
// write-back data cache.
package dcache_pkg;

   localparam int INDEX_W  = 5;
   localparam int OFFSET_W = 5;
   localparam int LINE_W   = 8 * (2 ** OFFSET_W);
   localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
   localparam int WORD_W   = OFFSET_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      ALLOCATE,
      REFILL_DONE
   } state_t;

   // Pick the 32-bit word at position 'word' out of a cache line.
   function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line,
                                            input logic [WORD_W-1:0] word);
      logic [LINE_W-1:0] w_shifted;
      w_shifted = line >> {word, 5'd0};
      return w_shifted[31:0];
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache; the cache takes the
// slave view, the CPU/memory environment the master view.
interface dcache_if #(
   parameter int LINE_W = dcache_pkg::LINE_W
) ();

   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [31:0]       cpu_addr_i;
   logic [31:0]       cpu_data_i;
   logic [31:0]       cpu_data_o;
   logic              stall_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      output cpu_data_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      input  cpu_data_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

endinterface

// File: rtl/dcache_sram.sv
// Line storage of the cache: valid/dirty/tag/data arrays, read asynchronously at
// one index, written by a full-line refill port and a single-word store port.
module dcache_sram #(
   parameter int INDEX_W  = dcache_pkg::INDEX_W,
   parameter int OFFSET_W = dcache_pkg::OFFSET_W,
   parameter int LINE_W   = dcache_pkg::LINE_W,
   parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [INDEX_W-1:0]  i_idx,
   output logic                o_valid,
   output logic                o_dirty,
   output logic [TAG_W-1:0]    o_tag,
   output logic [LINE_W-1:0]   o_line,
   input  logic                i_line_we,
   input  logic [TAG_W-1:0]    i_line_tag,
   input  logic [LINE_W-1:0]   i_line_data,
   input  logic                i_word_we,
   input  logic [OFFSET_W-3:0] i_word,
   input  logic [31:0]         i_word_data,
   input  logic                i_clr_dirty
);
   import dcache_pkg::*;

   localparam int LINES = 2 ** INDEX_W;
   localparam int WORDS = 2 ** (OFFSET_W - 2);

   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [TAG_W-1:0]  r_tag  [LINES];
   logic [LINE_W-1:0] r_data [LINES];

   assign o_valid = r_valid[i_idx];
   assign o_dirty = r_dirty[i_idx];
   assign o_tag   = r_tag[i_idx];
   assign o_line  = r_data[i_idx];

   // NOTE: state is updated with <= so every flop samples pre-edge values,
   // independent of the order the always blocks are evaluated in.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_line_we) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_word_we) begin
         r_dirty[i_idx] <= 1'b1;
      end else if (i_clr_dirty) begin
         r_dirty[i_idx] <= 1'b0;
      end
   end

   // NOTE: tag and data arrays carry no reset; valid gates every use of them,
   // so clearing valid alone is enough and keeps these mappable to RAM.
   always_ff @(posedge clk_i) begin
      if (i_line_we) begin
         r_tag[i_idx]  <= i_line_tag;
         r_data[i_idx] <= i_line_data;
      end else if (i_word_we) begin
         for (int w = 0; w < WORDS; w++) begin
            if (i_word == w[OFFSET_W-3:0]) r_data[i_idx][w*32 +: 32] <= i_word_data;
         end
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data-cache controller: zero-latency
// hits, stall plus write-back/refill handshake with memory on a miss.
module dcache_ctrl #(
   parameter int INDEX_W  = dcache_pkg::INDEX_W,
   parameter int OFFSET_W = dcache_pkg::OFFSET_W,
   parameter int LINE_W   = dcache_pkg::LINE_W,
   parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
   input  logic     clk_i,
   input  logic     rst_i,
   dcache_if.slave  bus
);
   import dcache_pkg::*;

   state_t              r_state;
   state_t              w_next;
   logic [TAG_W-1:0]    w_req_tag;
   logic [INDEX_W-1:0]  w_idx;
   logic [OFFSET_W-3:0] w_word;
   logic                w_unused_addr;
   logic                w_valid;
   logic                w_dirty;
   logic [TAG_W-1:0]    w_vic_tag;
   logic [LINE_W-1:0]   w_line;
   logic                w_hit;
   logic                w_line_we;
   logic                w_word_we;
   logic                w_clr_dirty;
   logic                w_mem_en;
   logic                w_mem_wr;
   logic [31:0]         w_mem_addr;
   logic [LINE_W-1:0]   w_mem_data;

   assign w_req_tag     = bus.cpu_addr_i[31 -: TAG_W];
   assign w_idx         = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
   assign w_word        = bus.cpu_addr_i[2 +: OFFSET_W-2];
   assign w_unused_addr = ^bus.cpu_addr_i[1:0];

   dcache_sram #(
      .INDEX_W  (INDEX_W),
      .OFFSET_W (OFFSET_W),
      .LINE_W   (LINE_W),
      .TAG_W    (TAG_W)
   ) u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_idx       (w_idx),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_vic_tag),
      .o_line      (w_line),
      .i_line_we   (w_line_we),
      .i_line_tag  (w_req_tag),
      .i_line_data (bus.mem_data_i),
      .i_word_we   (w_word_we),
      .i_word      (w_word),
      .i_word_data (bus.cpu_data_i),
      .i_clr_dirty (w_clr_dirty)
   );

   assign w_hit          = bus.cpu_req_i & w_valid & (w_vic_tag == w_req_tag);
   assign bus.stall_o    = (bus.cpu_req_i & ~w_hit) | (r_state != IDLE);
   assign bus.cpu_data_o = w_hit ? word_sel(w_line, w_word) : 32'd0;

   // Stores merge only from IDLE; a store miss merges on the edge after REFILL_DONE.
   assign w_word_we = (r_state == IDLE) & w_hit & bus.cpu_we_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_next      = r_state;
      w_mem_en    = 1'b0;
      w_mem_wr    = 1'b0;
      w_mem_addr  = '0;
      w_mem_data  = '0;
      w_line_we   = 1'b0;
      w_clr_dirty = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.cpu_req_i && !w_hit) w_next = MISS;
         end
         MISS: begin
            w_next = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            w_mem_en   = 1'b1;
            w_mem_wr   = 1'b1;
            w_mem_addr = {w_vic_tag, w_idx, {OFFSET_W{1'b0}}};
            w_mem_data = w_line;
            if (bus.mem_ack_i) begin
               w_clr_dirty = 1'b1;
               w_next      = MISS;
            end
         end
         ALLOCATE: begin
            w_mem_en   = 1'b1;
            w_mem_addr = {w_req_tag, w_idx, {OFFSET_W{1'b0}}};
            if (bus.mem_ack_i) begin
               w_line_we = 1'b1;
               w_next    = REFILL_DONE;
            end
         end
         REFILL_DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign bus.mem_enable_o = w_mem_en;
   assign bus.mem_write_o  = w_mem_wr;
   assign bus.mem_addr_o   = w_mem_addr;
   assign bus.mem_data_o   = w_mem_data;

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller between the CPU MEM stage and the off-chip data memory. It answers CPU loads and stores from an internal line array on a hit. On a miss it raises `stall_o`, which freezes the PC and pipeline registers. While stalled it runs the write-back and refill handshake with memory.

## Interface
Parameters:
- `INDEX_W`, 5: index bits; 2^INDEX_W lines.
- `OFFSET_W`, 5: byte-offset bits; line = 2^OFFSET_W bytes.
- `LINE_W`, 256: line width in bits; must equal 8·2^OFFSET_W.
- `TAG_W`, 32−INDEX_W−OFFSET_W (22): tag width.

Ports:
- `clk_i`  in  1: clock clk_i.
- `rst_i`  in  1: reset rst_i, asynchronous, active-low.
- `cpu_req_i`  in  1: CPU access valid (MemRead | MemWrite).
- `cpu_we_i`  in  1: 1 = store, 0 = load.
- `cpu_addr_i`  in  32: byte address; bits [1:0] ignored.
- `cpu_data_i`  in  32: store data.
- `cpu_data_o`  out  32: load data.
- `stall_o`  out  1: freeze pipeline/PC.
- `mem_enable_o`  out  1: memory request.
- `mem_write_o`  out  1: 1 = line write, 0 = line read.
- `mem_addr_o`  out  32: line-aligned address; low OFFSET_W bits are 0.
- `mem_data_o`  out  LINE_W: write-back line.
- `mem_data_i`  in  LINE_W: refill line.
- `mem_ack_i`  in  1: one-cycle completion pulse.

## Operation
- Address split: tag = [31:INDEX_W+OFFSET_W], index = [INDEX_W+OFFSET_W−1:OFFSET_W], word = [OFFSET_W−1:2].
- Per line state: valid, dirty, tag, data.
- `hit` = `cpu_req_i` & valid[index] & (tag[index] == addr tag).
- `stall_o` = (`cpu_req_i` & ~`hit`) | (state ≠ IDLE). This is combinational, so a miss stalls in the cycle it is presented.
- The CPU holds `cpu_*` stable while `stall_o` = 1.
- Load hit: `cpu_data_o` = selected word, combinational, same cycle.
- Store hit: at the clock edge, the selected word is replaced and dirty is set.
- `cpu_data_o` = 0 when there is no hit.
- FSM states and transitions:
  - **IDLE**: on `cpu_req_i` & ~`hit`, go to MISS.
  - **MISS**: memory outputs idle. If the victim is valid & dirty, go to WRITEBACK; else go to ALLOCATE.
  - **WRITEBACK**:
    - Drives `mem_enable_o` = 1, `mem_write_o` = 1, `mem_addr_o` = {victim tag, index, 0}, `mem_data_o` = victim line.
    - On `mem_ack_i`: clear dirty and go to MISS. MISS then sees a clean victim and goes to ALLOCATE.
  - **ALLOCATE**:
    - Drives `mem_enable_o` = 1, `mem_write_o` = 0, `mem_addr_o` = {req tag, index, 0}.
    - On `mem_ack_i`: write the line from `mem_data_i` and set valid = 1, dirty = 0, tag = req tag. Go to REFILL_DONE.
  - **REFILL_DONE**: go to IDLE. The held request now hits. A store merges at that IDLE edge.
- Memory handshake:
  - Request signals are level-held until `mem_ack_i`.
  - `mem_enable_o` drops for at least one cycle between consecutive requests (guaranteed by MISS / REFILL_DONE).
  - `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored.
- `mem_data_o` = 0 and `mem_addr_o` = 0 whenever `mem_enable_o` = 0.

## Timing
- Reset, asynchronous and valid mid-operation:
  - state = IDLE; all valid and dirty = 0; `mem_enable_o` = 0, `mem_write_o` = 0.
  - `mem_addr_o` = 0, `mem_data_o` = 0; `cpu_data_o` = 0; `stall_o` = `cpu_req_i`.
  - An in-flight memory transaction is abandoned; a late ack is ignored.
- Hit: 0-cycle latency, no stall.
- Clean miss:
  - Cycle 0: IDLE, stall.
  - Cycle 1: MISS.
  - Cycles 2..A: ALLOCATE, where A is the ack cycle.
  - Cycle A+1: REFILL_DONE.
  - Cycle A+2: IDLE, hit, `stall_o` = 0.
- Dirty miss: inserts WRITEBACK (cycles 2..W) and MISS (W+1) before ALLOCATE.
- An ack in the first cycle of WRITEBACK or ALLOCATE is legal; minimum clean-miss stall is 4 cycles.
- Only one outstanding memory request at any time.

## Structure
- Package `dcache_pkg`:
  - state enum {IDLE, MISS, WRITEBACK, ALLOCATE, REFILL_DONE};
  - default INDEX_W/OFFSET_W/LINE_W constants and derived TAG_W;
  - word-select helper function.
- Sub-module `dcache_sram`:
  - valid/dirty/tag/data arrays with asynchronous read;
  - synchronous write with a line-write port and a word-write port (plus dirty set);
  - asynchronous clear of valid/dirty on `rst_i`.
- The FSM, hit logic and muxes live in `dcache_ctrl`.

## Test plan
- **Cold load miss**: reset, load 0x0000_0104. Response: stall 1 cycle later in MISS; ALLOCATE with `mem_addr_o` = 0x0000_0100, `mem_write_o` = 0. Ack with line word1 = 0xDEAD_BEEF; `cpu_data_o` = 0xDEAD_BEEF and `stall_o` = 0 two cycles after the ack.
- **Store hit then load**: store 0x1234_5678 to 0x104, then load 0x104. Response: no stall; load returns 0x1234_5678; dirty[8] = 1.
- **Dirty eviction**: after the store test, load 0x0000_2104 (same index 8). Response: WRITEBACK with `mem_addr_o` = 0x100 and `mem_data_o` word1 = 0x1234_5678. `mem_enable_o` is low for one cycle, then ALLOCATE at 0x2100.
- **Write miss (allocate)**: store 0xAAAA_5555 to 0x308 with the line absent. Response: refill from 0x300; after the stall drops the line holds 0xAAAA_5555 in word2 and dirty = 1.
- **Slow memory**: ack delayed 10 cycles. Response: `mem_enable_o`, `mem_addr_o` and `mem_write_o` are stable throughout; `stall_o` holds; a spurious ack in IDLE is ignored.
- **Reset mid-refill**: assert `rst_i` = 0 in ALLOCATE. Response: `mem_enable_o` = 0 immediately, state = IDLE, all lines invalid. A later ack has no effect, and a re-issued load misses again.
